// File: rtl/sprite_sched_pkg.sv
// Shared types and helpers for the per-line sprite scheduler.
// Struct widths follow the default parameter set used by sprite_line_sched.
package sprite_sched_pkg;

  localparam int DEF_CORDW      = 16;
  localparam int DEF_SPR_CNT    = 8;
  localparam int DEF_SLOTS      = 4;
  localparam int DEF_SPR_WIDTH  = 8;
  localparam int DEF_SPR_HEIGHT = 8;
  localparam int DEF_SPR_DATAW  = 1;
  localparam int DEF_IDW        = $clog2(DEF_SPR_CNT);
  localparam int DEF_ROWW       = (DEF_SPR_HEIGHT > 1) ? $clog2(DEF_SPR_HEIGHT) : 1;
  localparam int DEF_BITSW      = DEF_SPR_WIDTH * DEF_SPR_DATAW;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_FETCH = 2'd2
  } sched_state_e;

  typedef struct packed {
    logic signed [DEF_CORDW-1:0] x;
    logic signed [DEF_CORDW-1:0] y;
    logic                        en;
  } attr_t;

  typedef struct packed {
    logic                        valid;
    logic [DEF_IDW-1:0]          idx;
    logic signed [DEF_CORDW-1:0] x;
    logic [DEF_ROWW-1:0]         row;
    logic [DEF_BITSW-1:0]        bits;
  } slot_t;

  // One extra bit keeps the difference exact for any pair of coordinates.
  function automatic logic signed [DEF_CORDW:0] coord_diff(
    input logic signed [DEF_CORDW-1:0] a,
    input logic signed [DEF_CORDW-1:0] b
  );
    return {a[DEF_CORDW-1], a} - {b[DEF_CORDW-1], b};
  endfunction

endpackage

// File: rtl/sprite_attr_table.sv
// Sprite attribute register file: one synchronous write port, one
// combinational read port, every entry disabled by reset.
module sprite_attr_table
  import sprite_sched_pkg::*;
#(
  parameter int SPR_CNT = DEF_SPR_CNT,
  parameter int IDW     = $clog2(SPR_CNT)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           we,
  input  logic [IDW-1:0] widx,
  input  attr_t          wdata,
  input  logic [IDW-1:0] ridx,
  output attr_t          rdata
);

  attr_t mem [SPR_CNT];

  // Table storage; a same-cycle read sees the value before the write lands.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SPR_CNT; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[widx] <= wdata;
    end
  end

  assign rdata = mem[ridx];

endmodule

// File: rtl/sprite_line_sched.sv
// Per-line sprite scheduler: scans the attribute table during blanking,
// fetches one bitmap row per allocated slot and composites the slots.
module sprite_line_sched
  import sprite_sched_pkg::*;
#(
  parameter int CORDW      = DEF_CORDW,
  parameter int SPR_CNT    = DEF_SPR_CNT,
  parameter int SLOTS      = DEF_SLOTS,
  parameter int SPR_WIDTH  = DEF_SPR_WIDTH,
  parameter int SPR_HEIGHT = DEF_SPR_HEIGHT,
  parameter int SPR_DATAW  = DEF_SPR_DATAW,
  parameter int IDW        = $clog2(SPR_CNT),
  parameter int ADDRW      = $clog2(SPR_CNT*SPR_HEIGHT)
) (
  input  logic                          clk_pix,
  input  logic                          rst_pix,
  input  logic                          line,
  input  logic signed [CORDW-1:0]       sx,
  input  logic signed [CORDW-1:0]       sy,
  input  logic                          attr_we,
  input  logic [IDW-1:0]                attr_idx,
  input  logic signed [CORDW-1:0]       attr_x,
  input  logic signed [CORDW-1:0]       attr_y,
  input  logic                          attr_en,
  output logic                          rom_re,
  output logic [ADDRW-1:0]              rom_addr,
  input  logic [SPR_WIDTH*SPR_DATAW-1:0] rom_data,
  output logic [SPR_DATAW-1:0]          pix,
  output logic                          drawing,
  output logic [IDW-1:0]                spr_id,
  output logic                          overflow,
  output logic                          busy
);

  localparam int ROWW  = (SPR_HEIGHT > 1) ? $clog2(SPR_HEIGHT) : 1;
  localparam int COLW  = (SPR_WIDTH > 1) ? $clog2(SPR_WIDTH) : 1;
  localparam int CNTW  = $clog2(SLOTS + 1);
  localparam int SIDXW = (SLOTS > 1) ? $clog2(SLOTS) : 1;

  function automatic logic [ADDRW-1:0] row_addr(
    input logic [IDW-1:0]  idx,
    input logic [ROWW-1:0] row
  );
    return ADDRW'(idx) * ADDRW'(SPR_HEIGHT) + ADDRW'(row);
  endfunction

  sched_state_e     state;
  logic [IDW-1:0]   scan_idx;
  logic [CNTW-1:0]  slot_cnt;
  logic [CNTW-1:0]  fcnt;
  logic             ovf_pend;
  slot_t            slots [SLOTS];

  attr_t            wr_attr;
  attr_t            rd_attr;

  logic signed [CORDW:0] dy;
  logic             hit;
  logic             has_room;
  logic             scan_last;
  slot_t            new_slot;
  logic [CNTW-1:0]  n_final;
  logic [SIDXW-1:0] alloc_sidx;
  logic [SIDXW-1:0] cap_sidx;
  logic [SIDXW-1:0] nxt_sidx;
  logic [ADDRW-1:0] first_addr;
  logic [ADDRW-1:0] nxt_addr;

  logic signed [CORDW:0] dx [SLOTS];
  logic [SPR_DATAW-1:0]  spx [SLOTS];
  logic [SLOTS-1:0]      opaque;
  logic                  win_hit;
  logic [SPR_DATAW-1:0]  win_pix;
  logic [IDW-1:0]        win_id;

  assign wr_attr = '{x: attr_x, y: attr_y, en: attr_en};

  sprite_attr_table #(
    .SPR_CNT (SPR_CNT),
    .IDW     (IDW)
  ) u_attr (
    .clk   (clk_pix),
    .rst   (rst_pix),
    .we    (attr_we),
    .widx  (attr_idx),
    .wdata (wr_attr),
    .ridx  (scan_idx),
    .rdata (rd_attr)
  );

  // Hit test for the entry under scan plus the slot/ROM indices in use.
  always_comb begin
    dy         = coord_diff(sy, rd_attr.y);
    hit        = rd_attr.en && !dy[CORDW] && (dy[CORDW-1:0] <= CORDW'(SPR_HEIGHT - 1));
    has_room   = slot_cnt < CNTW'(SLOTS);
    scan_last  = scan_idx == IDW'(SPR_CNT - 1);
    new_slot   = '{valid: 1'b0, idx: scan_idx, x: rd_attr.x, row: dy[ROWW-1:0], bits: '0};
    n_final    = slot_cnt + CNTW'(hit && has_room);
    alloc_sidx = SIDXW'(slot_cnt);
    cap_sidx   = SIDXW'(fcnt - CNTW'(1));
    nxt_sidx   = SIDXW'(fcnt + CNTW'(1));
    nxt_addr   = row_addr(slots[nxt_sidx].idx, slots[nxt_sidx].row);
    // The first read is issued on the SCAN exit edge, so slot 0 may still be in flight.
    if (slot_cnt == '0) begin
      first_addr = row_addr(scan_idx, dy[ROWW-1:0]);
    end else begin
      first_addr = row_addr(slots[0].idx, slots[0].row);
    end
  end

  // Scheduler FSM: line restarts everything, SCAN allocates, FETCH fills rows.
  always_ff @(posedge clk_pix or posedge rst_pix) begin
    if (rst_pix) begin
      state    <= ST_IDLE;
      scan_idx <= '0;
      slot_cnt <= '0;
      fcnt     <= '0;
      ovf_pend <= 1'b0;
      busy     <= 1'b0;
      overflow <= 1'b0;
      rom_re   <= 1'b0;
      rom_addr <= '0;
      for (int i = 0; i < SLOTS; i++) begin
        slots[i] <= '0;
      end
    end else begin
      overflow <= 1'b0;
      rom_re   <= 1'b0;
      if (line) begin
        state    <= ST_SCAN;
        busy     <= 1'b1;
        scan_idx <= '0;
        slot_cnt <= '0;
        fcnt     <= '0;
        ovf_pend <= 1'b0;
        for (int i = 0; i < SLOTS; i++) begin
          slots[i].valid <= 1'b0;
        end
      end else begin
        case (state)
          ST_IDLE: begin
            busy <= 1'b0;
          end
          ST_SCAN: begin
            if (hit && has_room) begin
              slots[alloc_sidx] <= new_slot;
              slot_cnt          <= slot_cnt + CNTW'(1);
            end else if (hit) begin
              ovf_pend <= 1'b1;
            end
            if (scan_last) begin
              state    <= ST_FETCH;
              fcnt     <= '0;
              overflow <= ovf_pend || (hit && !has_room);
              if (n_final != '0) begin
                rom_re   <= 1'b1;
                rom_addr <= first_addr;
              end
            end else begin
              scan_idx <= scan_idx + IDW'(1);
            end
          end
          ST_FETCH: begin
            // fcnt counts FETCH cycles; the data for slot fcnt-1 is on rom_data now.
            if (fcnt != '0) begin
              slots[cap_sidx].bits  <= rom_data;
              slots[cap_sidx].valid <= 1'b1;
            end
            if (fcnt == slot_cnt) begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end else begin
              fcnt <= fcnt + CNTW'(1);
              if ((fcnt + CNTW'(1)) < slot_cnt) begin
                rom_re   <= 1'b1;
                rom_addr <= nxt_addr;
              end
            end
          end
          default: begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  // Per-slot column select and opacity at the current sx.
  always_comb begin
    for (int i = 0; i < SLOTS; i++) begin
      dx[i]     = coord_diff(sx, slots[i].x);
      spx[i]    = slots[i].bits[dx[i][COLW-1:0]*SPR_DATAW +: SPR_DATAW];
      opaque[i] = slots[i].valid && !dx[i][CORDW]
                  && (dx[i][CORDW-1:0] <= CORDW'(SPR_WIDTH - 1))
                  && (spx[i] != '0);
    end
  end

  // Walk from the highest slot down so the lowest opaque slot is left standing.
  always_comb begin
    win_hit = 1'b0;
    win_pix = '0;
    win_id  = '0;
    for (int i = SLOTS - 1; i >= 0; i--) begin
      if (opaque[i]) begin
        win_hit = 1'b1;
        win_pix = spx[i];
        win_id  = slots[i].idx;
      end else begin
        win_hit = win_hit;
      end
    end
  end

  // Registered composite output, blanked while the slots are being rebuilt.
  always_ff @(posedge clk_pix or posedge rst_pix) begin
    if (rst_pix) begin
      pix     <= '0;
      drawing <= 1'b0;
      spr_id  <= '0;
    end else if (busy) begin
      pix     <= '0;
      drawing <= 1'b0;
      spr_id  <= '0;
    end else begin
      pix     <= win_pix;
      drawing <= win_hit;
      spr_id  <= win_id;
    end
  end

endmodule
